// File: rtl/ac_motor_ramp_ctrl_if.sv
// Command handshake bundle between a command source (master) and ac_motor_ramp_ctrl (slave).
interface ac_motor_ramp_ctrl_if;
  localparam int unsigned DW = 12;

  logic          CMD_VALID;
  logic          CMD_READY;
  logic          CMD_STOP;
  logic          CMD_DIR;
  logic [DW-1:0] CMD_AMPLITUDE;
  logic [DW-1:0] CMD_FREQUENCY;

  modport master (
    output CMD_VALID, CMD_STOP, CMD_DIR, CMD_AMPLITUDE, CMD_FREQUENCY,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID, CMD_STOP, CMD_DIR, CMD_AMPLITUDE, CMD_FREQUENCY,
    output CMD_READY
  );
endinterface

// File: rtl/ac_motor_ramp_ctrl.sv
// AC motor PWM configuration sequencer: ramped start/stop and dead-time direction reversal.
// Optional over-current trip is built when AC_MOTOR_RAMP_OC_TRIP_EN is defined.
module ac_motor_ramp_ctrl #(
  parameter int unsigned RAMP_DIV    = 1000,
  parameter int unsigned AMP_STEP    = 16,
  parameter int unsigned FREQ_START  = 4095,
  parameter int unsigned DEAD_CYCLES = 500
) (
  input  logic                       CLK,
  input  logic                       RESET,
  ac_motor_ramp_ctrl_if.slave        cmd,
  output logic                       ENABLE,
  output logic                       CW,
  output logic                       CCW,
  output logic [11:0]                AMPLITUDE,
  output logic [11:0]                FREQUENCY,
  output logic                       BUSY,
  output logic [2:0]                 STATE
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
  ,
  input  logic [11:0]                ADC,
  input  logic [11:0]                ADC_LIMIT,
  input  logic                       FAULT_CLEAR,
  output logic                       FAULT
`endif
);

  localparam int unsigned DW      = 12;
  localparam int unsigned PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned DEAD_W  = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [DW-1:0] FS    = DW'(FREQ_START);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SLEW      = 3'd1,
    S_RUN       = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_DEAD      = 3'd4
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_en, w_en_nxt;
  logic                r_cw, w_cw_nxt;
  logic                r_ccw, w_ccw_nxt;
  logic [DW-1:0]       r_amp, w_amp_nxt;
  logic [DW-1:0]       r_freq, w_freq_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_busy, w_busy_nxt;
  logic [DEAD_W-1:0]   r_dead, w_dead_nxt;
  logic                r_pend, w_pend_nxt;
  logic [DW-1:0]       r_tgt_amp, w_tgt_amp_nxt;
  logic [DW-1:0]       r_tgt_freq, w_tgt_freq_nxt;
  logic                r_tgt_dir, w_tgt_dir_nxt;
  logic [PRESC_W-1:0]  r_presc;
  logic                w_tick;
  logic                w_accept;
  logic                w_cmd_stop;
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
  logic                r_fault, w_fault_nxt;
  logic                r_adc_hi;
  logic                w_adc_hi;
  logic                w_trip;
`endif

  // Amplitude moves by AMP_STEP, snapping to the target once within one step.
  function automatic logic [DW-1:0] f_amp_toward(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
    logic [DW-1:0] diff;
    diff = (cur > tgt) ? (cur - tgt) : (tgt - cur);
    if (32'(diff) <= AMP_STEP) return tgt;
    else if (cur > tgt)        return cur - DW'(AMP_STEP);
    else                       return cur + DW'(AMP_STEP);
  endfunction

  function automatic logic [DW-1:0] f_freq_toward(input logic [DW-1:0] cur, input logic [DW-1:0] tgt);
    if (cur < tgt)      return cur + DW'(1);
    else if (cur > tgt) return cur - DW'(1);
    else                return cur;
  endfunction

  assign w_tick     = (r_presc == PRESC_W'(RAMP_DIV - 1));
  assign w_accept   = cmd.CMD_VALID && r_ready;
  assign w_cmd_stop = cmd.CMD_STOP || (cmd.CMD_AMPLITUDE == '0);

`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
  assign w_adc_hi = (ADC > ADC_LIMIT);
  assign w_trip   = w_adc_hi && r_adc_hi && (r_state != S_IDLE);
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_en_nxt       = r_en;
    w_cw_nxt       = r_cw;
    w_ccw_nxt      = r_ccw;
    w_amp_nxt      = r_amp;
    w_freq_nxt     = r_freq;
    w_dead_nxt     = r_dead;
    w_pend_nxt     = r_pend;
    w_tgt_amp_nxt  = r_tgt_amp;
    w_tgt_freq_nxt = r_tgt_freq;
    w_tgt_dir_nxt  = r_tgt_dir;
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
    w_fault_nxt    = r_fault;
`endif

    unique case (r_state)
      S_IDLE: begin
        if (w_accept && !w_cmd_stop) begin
          w_tgt_amp_nxt  = cmd.CMD_AMPLITUDE;
          w_tgt_freq_nxt = cmd.CMD_FREQUENCY;
          w_tgt_dir_nxt  = cmd.CMD_DIR;
          w_en_nxt       = 1'b1;
          w_cw_nxt       = cmd.CMD_DIR;
          w_ccw_nxt      = !cmd.CMD_DIR;
          w_amp_nxt      = '0;
          w_freq_nxt     = FS;
          w_state_nxt    = S_SLEW;
        end
      end
      S_SLEW: begin
        if ((r_amp == r_tgt_amp) && (r_freq == r_tgt_freq)) begin
          w_state_nxt = S_RUN;
        end else if (w_tick) begin
          w_amp_nxt  = f_amp_toward(r_amp, r_tgt_amp);
          w_freq_nxt = f_freq_toward(r_freq, r_tgt_freq);
        end
      end
      S_RUN: begin
        if (w_accept) begin
          if (w_cmd_stop) begin
            w_pend_nxt  = 1'b1;
            w_state_nxt = S_RAMP_DOWN;
          end else begin
            w_tgt_amp_nxt  = cmd.CMD_AMPLITUDE;
            w_tgt_freq_nxt = cmd.CMD_FREQUENCY;
            w_tgt_dir_nxt  = cmd.CMD_DIR;
            w_pend_nxt     = 1'b0;
            w_state_nxt    = (cmd.CMD_DIR != r_tgt_dir) ? S_RAMP_DOWN : S_SLEW;
          end
        end
      end
      S_RAMP_DOWN: begin
        if ((r_amp == '0) && (r_freq == FS)) begin
          w_cw_nxt    = 1'b0;
          w_ccw_nxt   = 1'b0;
          w_dead_nxt  = DEAD_W'(DEAD_CYCLES - 1);
          w_state_nxt = S_DEAD;
        end else if (w_tick) begin
          w_amp_nxt  = f_amp_toward(r_amp, '0);
          w_freq_nxt = f_freq_toward(r_freq, FS);
        end
      end
      S_DEAD: begin
        // Bridge stays enabled but both directions are off for the whole dead time.
        if (r_dead == '0) begin
          if (r_pend) begin
            w_en_nxt    = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cw_nxt    = r_tgt_dir;
            w_ccw_nxt   = !r_tgt_dir;
            w_state_nxt = S_SLEW;
          end
        end else begin
          w_dead_nxt = r_dead - DEAD_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
    if (w_trip) begin
      w_state_nxt = S_IDLE;
      w_en_nxt    = 1'b0;
      w_cw_nxt    = 1'b0;
      w_ccw_nxt   = 1'b0;
      w_amp_nxt   = '0;
      w_freq_nxt  = FS;
      w_pend_nxt  = 1'b0;
      w_fault_nxt = 1'b1;
    end else if (FAULT_CLEAR) begin
      w_fault_nxt = 1'b0;
    end
    w_ready_nxt = ((w_state_nxt == S_IDLE) || (w_state_nxt == S_RUN)) && !w_fault_nxt;
`else
    w_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_RUN);
`endif
    w_busy_nxt = (w_state_nxt == S_SLEW) || (w_state_nxt == S_RAMP_DOWN) || (w_state_nxt == S_DEAD);
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_en       <= 1'b0;
      r_cw       <= 1'b0;
      r_ccw      <= 1'b0;
      r_amp      <= '0;
      r_freq     <= FS;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_dead     <= '0;
      r_pend     <= 1'b0;
      r_tgt_amp  <= '0;
      r_tgt_freq <= FS;
      r_tgt_dir  <= 1'b0;
      r_presc    <= '0;
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
      r_fault    <= 1'b0;
      r_adc_hi   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_en       <= w_en_nxt;
      r_cw       <= w_cw_nxt;
      r_ccw      <= w_ccw_nxt;
      r_amp      <= w_amp_nxt;
      r_freq     <= w_freq_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_dead     <= w_dead_nxt;
      r_pend     <= w_pend_nxt;
      r_tgt_amp  <= w_tgt_amp_nxt;
      r_tgt_freq <= w_tgt_freq_nxt;
      r_tgt_dir  <= w_tgt_dir_nxt;
      r_presc    <= w_tick ? '0 : (r_presc + PRESC_W'(1));
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
      r_fault    <= w_fault_nxt;
      r_adc_hi   <= w_adc_hi;
`endif
    end
  end

  assign cmd.CMD_READY = r_ready;
  assign ENABLE        = r_en;
  assign CW            = r_cw;
  assign CCW           = r_ccw;
  assign AMPLITUDE     = r_amp;
  assign FREQUENCY     = r_freq;
  assign BUSY          = r_busy;
  assign STATE         = r_state;
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
  assign FAULT         = r_fault;
`endif

endmodule

// File: tb/tb_ac_motor_ramp_ctrl.sv
// Bench for ac_motor_ramp_ctrl: start-up vector table, directed corner sequences and
// random commands checked every cycle against a behavioural model.
module tb_ac_motor_ramp_ctrl;
  localparam int RAMP_DIV    = 4;
  localparam int AMP_STEP    = 16;
  localparam int FREQ_START  = 4095;
  localparam int DEAD_CYCLES = 6;

  localparam int ST_IDLE = 0, ST_SLEW = 1, ST_RUN = 2, ST_RD = 3, ST_DEAD = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE, CW, CCW, BUSY;
  logic [11:0] AMPLITUDE, FREQUENCY;
  logic [2:0]  STATE;
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
  logic [11:0] ADC, ADC_LIMIT;
  logic        FAULT_CLEAR, FAULT;
`endif

  ac_motor_ramp_ctrl_if bus ();

  ac_motor_ramp_ctrl #(
    .RAMP_DIV   (RAMP_DIV),
    .AMP_STEP   (AMP_STEP),
    .FREQ_START (FREQ_START),
    .DEAD_CYCLES(DEAD_CYCLES)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .cmd       (bus),
    .ENABLE    (ENABLE),
    .CW        (CW),
    .CCW       (CCW),
    .AMPLITUDE (AMPLITUDE),
    .FREQUENCY (FREQUENCY),
    .BUSY      (BUSY),
    .STATE     (STATE)
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
    ,
    .ADC        (ADC),
    .ADC_LIMIT  (ADC_LIMIT),
    .FAULT_CLEAR(FAULT_CLEAR),
    .FAULT      (FAULT)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Behavioural model state (plain integers).
  int m_state, m_amp, m_freq, m_presc, m_dead_left, m_tamp, m_tfreq;
  bit m_en, m_cw, m_ccw, m_pend, m_tdir, m_fault, m_prev_hi;

  function automatic bit m_ready();
    return ((m_state == ST_IDLE) || (m_state == ST_RUN)) && !m_fault;
  endfunction

  function automatic bit m_busy();
    return (m_state == ST_SLEW) || (m_state == ST_RD) || (m_state == ST_DEAD);
  endfunction

  // Move cur toward tgt by at most step.
  function automatic int toward(input int cur, input int tgt, input int step);
    int d;
    d = tgt - cur;
    if (d > step)  d = step;
    if (d < -step) d = -step;
    return cur + d;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit acc, stopish, tick;
    int old_state;
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
    bit hi;
`endif
    if (RESET) begin
      m_state = ST_IDLE; m_en = 0; m_cw = 0; m_ccw = 0; m_amp = 0; m_freq = FREQ_START;
      m_presc = 0; m_dead_left = 0; m_pend = 0; m_fault = 0; m_prev_hi = 0;
      m_tamp = 0; m_tfreq = FREQ_START; m_tdir = 0;
      return;
    end
    acc       = bus.CMD_VALID && m_ready();
    stopish   = bus.CMD_STOP || (bus.CMD_AMPLITUDE == 12'd0);
    tick      = (m_presc == RAMP_DIV - 1);
    m_presc   = (m_presc + 1) % RAMP_DIV;
    old_state = m_state;
    case (m_state)
      ST_IDLE: if (acc && !stopish) begin
        m_tamp = int'(bus.CMD_AMPLITUDE); m_tfreq = int'(bus.CMD_FREQUENCY); m_tdir = bus.CMD_DIR;
        m_en = 1; m_cw = bus.CMD_DIR; m_ccw = !bus.CMD_DIR; m_amp = 0; m_freq = FREQ_START;
        m_state = ST_SLEW;
      end
      ST_SLEW: begin
        if (m_amp == m_tamp && m_freq == m_tfreq) m_state = ST_RUN;
        else if (tick) begin
          m_amp  = toward(m_amp, m_tamp, AMP_STEP);
          m_freq = toward(m_freq, m_tfreq, 1);
        end
      end
      ST_RUN: if (acc) begin
        if (stopish) begin
          m_pend = 1; m_state = ST_RD;
        end else begin
          m_tamp = int'(bus.CMD_AMPLITUDE); m_tfreq = int'(bus.CMD_FREQUENCY);
          m_tdir = bus.CMD_DIR;
          if (bus.CMD_DIR != m_cw) begin m_pend = 0; m_state = ST_RD; end
          else m_state = ST_SLEW;
        end
      end
      ST_RD: begin
        if (m_amp == 0 && m_freq == FREQ_START) begin
          m_cw = 0; m_ccw = 0; m_dead_left = DEAD_CYCLES; m_state = ST_DEAD;
        end else if (tick) begin
          m_amp  = toward(m_amp, 0, AMP_STEP);
          m_freq = toward(m_freq, FREQ_START, 1);
        end
      end
      default: begin
        m_dead_left--;
        if (m_dead_left == 0) begin
          if (m_pend) begin m_en = 0; m_state = ST_IDLE; end
          else begin m_cw = m_tdir; m_ccw = !m_tdir; m_state = ST_SLEW; end
        end
      end
    endcase
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
    hi = (ADC > ADC_LIMIT);
    if (hi && m_prev_hi && old_state != ST_IDLE) begin
      m_fault = 1; m_en = 0; m_cw = 0; m_ccw = 0; m_amp = 0; m_freq = FREQ_START;
      m_pend = 0; m_state = ST_IDLE;
    end else if (FAULT_CLEAR) m_fault = 0;
    m_prev_hi = hi;
`else
    if (old_state < 0) m_state = ST_IDLE;
`endif
  endtask

  function automatic logic [39:0] pack(input logic [2:0] st, input logic en, cw, ccw,
                                       input logic [11:0] a, f, input logic rdy, bsy, flt);
    return {7'd0, flt, st, en, cw, ccw, a, f, rdy, bsy};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: update the model, let the DUT take the edge, compare all outputs.
  task automatic cycle();
    logic [39:0] act_v, exp_v;
    logic        dut_flt;
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
    dut_flt = FAULT;
`else
    dut_flt = 1'b0;
`endif
    model_step();
    @(posedge CLK);
    #1;
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
    dut_flt = FAULT;
`endif
    cyc++;
    act_v = pack(STATE, ENABLE, CW, CCW, AMPLITUDE, FREQUENCY, bus.CMD_READY, BUSY, dut_flt);
    exp_v = pack(3'(m_state), m_en, m_cw, m_ccw, 12'(m_amp), 12'(m_freq), m_ready(), m_busy(), m_fault);
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL outputs cycle %0d: got %h, expected %h", cyc, act_v, exp_v);
    end
  endtask

  task automatic set_cmd(input bit v, input bit s, input bit d, input int a, input int f);
    bus.CMD_VALID     = v;
    bus.CMD_STOP      = s;
    bus.CMD_DIR       = d;
    bus.CMD_AMPLITUDE = 12'(a);
    bus.CMD_FREQUENCY = 12'(f);
  endtask

  task automatic wait_state(input int st, input int budget, input string name);
    int n;
    n = 0;
    while (int'(STATE) != st && n < budget) begin cycle(); n++; end
    check(name, int'(STATE), st);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " STATE"}, int'(STATE), ST_IDLE);
    check({tag, " ENABLE"}, int'(ENABLE), 0);
    check({tag, " CW"}, int'(CW), 0);
    check({tag, " CCW"}, int'(CCW), 0);
    check({tag, " AMPLITUDE"}, int'(AMPLITUDE), 0);
    check({tag, " FREQUENCY"}, int'(FREQUENCY), FREQ_START);
    check({tag, " CMD_READY"}, int'(bus.CMD_READY), 1);
    check({tag, " BUSY"}, int'(BUSY), 0);
  endtask

  typedef struct {
    bit valid; bit dir; int amp; int freq;
    int e_state; int e_amp; int e_freq; bit e_cw; bit e_ccw; bit e_en; bit e_ready;
  } vec_t;

  function automatic vec_t mkv(input bit v, input bit d, input int a, input int f, input int es,
                               input int ea, input int ef, input bit ecw, input bit eccw,
                               input bit een, input bit erdy);
    vec_t r;
    r.valid = v; r.dir = d; r.amp = a; r.freq = f; r.e_state = es; r.e_amp = ea; r.e_freq = ef;
    r.e_cw = ecw; r.e_ccw = eccw; r.e_en = een; r.e_ready = erdy;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[17];
    int   q[$];
    int   exp_seq[3];
    int   n, prev;

    // Start-up from reset: ticks land on every 4th edge after reset release.
    vecs[0] = mkv(1, 1, 64, 4093, ST_SLEW, 0, 4095, 1, 0, 1, 0);
    for (int k = 2; k <= 16; k++)
      vecs[k-1] = mkv(0, 0, 0, 0, ST_SLEW, 16 * (k / 4), 4095 - ((k / 4) > 2 ? 2 : (k / 4)),
                      1, 0, 1, 0);
    vecs[16] = mkv(0, 0, 0, 0, ST_RUN, 64, 4093, 1, 0, 1, 1);
    exp_seq[0] = 16; exp_seq[1] = 32; exp_seq[2] = 40;

    RESET = 1'b1;
    set_cmd(0, 0, 0, 0, 0);
`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
    ADC = 12'd0; ADC_LIMIT = 12'd1500; FAULT_CLEAR = 1'b0;
`endif
    cycle(); cycle();
    check_reset_values("reset");
    RESET = 1'b0;

    for (int i = 0; i < 17; i++) begin
      set_cmd(vecs[i].valid, 0, vecs[i].dir, vecs[i].amp, vecs[i].freq);
      cycle();
      check($sformatf("vec%0d STATE", i), int'(STATE), vecs[i].e_state);
      check($sformatf("vec%0d AMPLITUDE", i), int'(AMPLITUDE), vecs[i].e_amp);
      check($sformatf("vec%0d FREQUENCY", i), int'(FREQUENCY), vecs[i].e_freq);
      check($sformatf("vec%0d CW", i), int'(CW), int'(vecs[i].e_cw));
      check($sformatf("vec%0d CCW", i), int'(CCW), int'(vecs[i].e_ccw));
      check($sformatf("vec%0d ENABLE", i), int'(ENABLE), int'(vecs[i].e_en));
      check($sformatf("vec%0d CMD_READY", i), int'(bus.CMD_READY), int'(vecs[i].e_ready));
    end

    // Reversal CW -> CCW through ramp-down and dead time.
    set_cmd(1, 0, 0, 32, 4093);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    check("rev ramp_down", int'(STATE), ST_RD);
    wait_state(ST_DEAD, 200, "rev reach DEAD");
    check("rev dead AMPLITUDE", int'(AMPLITUDE), 0);
    check("rev dead FREQUENCY", int'(FREQUENCY), FREQ_START);
    check("rev dead ENABLE", int'(ENABLE), 1);
    n = 1;
    while (int'(STATE) == ST_DEAD && n <= 100) begin
      check("rev dead dirs off", int'({CW, CCW}), 0);
      cycle();
      if (int'(STATE) == ST_DEAD) n++;
    end
    check("rev dead length", n, DEAD_CYCLES);
    check("rev after dead STATE", int'(STATE), ST_SLEW);
    check("rev after dead CCW", int'(CCW), 1);
    check("rev after dead CW", int'(CW), 0);
    wait_state(ST_RUN, 200, "rev reach RUN");
    check("rev run AMPLITUDE", int'(AMPLITUDE), 32);

    // Stop from RUN, then a zero-amplitude run command in IDLE.
    set_cmd(1, 1, 0, 0, 0);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    check("stop ramp_down", int'(STATE), ST_RD);
    wait_state(ST_DEAD, 200, "stop reach DEAD");
    wait_state(ST_IDLE, 50, "stop reach IDLE");
    check("stop ENABLE", int'(ENABLE), 0);
    check("stop CMD_READY", int'(bus.CMD_READY), 1);
    set_cmd(1, 0, 1, 0, 4000);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    check("amp0 stays IDLE", int'(STATE), ST_IDLE);
    check("amp0 ENABLE", int'(ENABLE), 0);

    // Target not a multiple of AMP_STEP.
    set_cmd(1, 0, 1, 40, 4095);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    prev = 0;
    n = 0;
    while (int'(STATE) != ST_RUN && n < 100) begin
      cycle(); n++;
      if (int'(AMPLITUDE) != prev) begin q.push_back(int'(AMPLITUDE)); prev = int'(AMPLITUDE); end
    end
    check("nonmult steps", q.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("nonmult step%0d", i), (i < q.size()) ? q[i] : -1, exp_seq[i]);
    check("nonmult RUN", int'(STATE), ST_RUN);

    // Backpressure: command held through SLEW, accepted once on the first RUN cycle.
    set_cmd(1, 0, 1, 64, 4094);
    cycle();
    set_cmd(1, 0, 1, 24, 4095);
    n = 0;
    while (int'(STATE) == ST_SLEW && n < 200) begin
      check("bp ready low", int'(bus.CMD_READY), 0);
      cycle(); n++;
    end
    check("bp RUN", int'(STATE), ST_RUN);
    check("bp target amp kept", int'(AMPLITUDE), 64);
    check("bp target freq kept", int'(FREQUENCY), 4094);
    check("bp ready high", int'(bus.CMD_READY), 1);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    check("bp accepted", int'(STATE), ST_SLEW);
    wait_state(ST_RUN, 200, "bp new RUN");
    check("bp new amp", int'(AMPLITUDE), 24);
    for (int i = 0; i < 4; i++) cycle();
    check("bp single accept", int'(STATE), ST_RUN);

    // RESET asserted while in DEAD.
    set_cmd(1, 1, 0, 0, 0);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    wait_state(ST_DEAD, 200, "rst reach DEAD");
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    check_reset_values("dead reset");

    // Random commands against the model.
    for (int i = 0; i < 3000; i++) begin
      RESET = ($urandom_range(0, 499) == 0);
      set_cmd($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 80)), int'($urandom_range(4088, 4095)));
      cycle();
    end
    RESET = 1'b0;
    set_cmd(0, 0, 0, 0, 0);

`ifdef AC_MOTOR_RAMP_OC_TRIP_EN
    // Over-current trip: one high sample is ignored, two consecutive trip.
    RESET = 1'b1;
    cycle();
    RESET = 1'b0;
    set_cmd(1, 0, 1, 32, 4095);
    cycle();
    set_cmd(0, 0, 0, 0, 0);
    wait_state(ST_RUN, 200, "oc reach RUN");
    ADC = 12'd2000;
    cycle();
    ADC = 12'd0;
    cycle();
    check("oc single FAULT", int'(FAULT), 0);
    check("oc single STATE", int'(STATE), ST_RUN);
    ADC = 12'd2000;
    cycle();
    check("oc first FAULT", int'(FAULT), 0);
    cycle();
    ADC = 12'd0;
    check("oc trip FAULT", int'(FAULT), 1);
    check("oc trip ENABLE", int'(ENABLE), 0);
    check("oc trip STATE", int'(STATE), ST_IDLE);
    check("oc trip READY", int'(bus.CMD_READY), 0);
    FAULT_CLEAR = 1'b1;
    cycle();
    FAULT_CLEAR = 1'b0;
    check("oc clear FAULT", int'(FAULT), 0);
    check("oc clear READY", int'(bus.CMD_READY), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
